// File: rtl/rx_controller.sv
// rx_controller: decodes raw receive sample words against the programmed
// frame format and queues data plus per-frame error status in a small FIFO.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   frame_i              raw 11-bit sample word, bit 0 = first bit after start
//   frame_valid_i        one-cycle strobe qualifying frame_i and the config
//   data_size_i          00=5, 01=6, 10=7, 11=8 data bits
//   parity_en_i          parity bit follows the data bits
//   parity_odd_i         1 = odd parity, 0 = even
//   stop_bits_i          0 = one stop bit, 1 = two stop bits
//   rx_ready_i           consumer pops the head entry while rx_valid_o is high
//   overrun_clr_i        clears the sticky overrun flag
//   rx_data_o            head data, zero above the configured width
//   rx_parity_err_o      head entry parity error
//   rx_frame_err_o       head entry stop-bit error
//   rx_valid_o           FIFO not empty
//   fifo_count_o         occupied FIFO entries, 0..FIFO_DEPTH
//   overrun_o            sticky: a decoded frame was dropped on a full FIFO
module rx_controller #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [10:0]                       frame_i,
    input  logic                              frame_valid_i,
    input  logic [1:0]                        data_size_i,
    input  logic                              parity_en_i,
    input  logic                              parity_odd_i,
    input  logic                              stop_bits_i,
    input  logic                              rx_ready_i,
    input  logic                              overrun_clr_i,
    output logic [7:0]                        rx_data_o,
    output logic                              rx_parity_err_o,
    output logic                              rx_frame_err_o,
    output logic                              rx_valid_o,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count_o,
    output logic                              overrun_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [7:0] data;
        logic       parity_err;
        logic       frame_err;
    } rx_entry_t;

    // Decode of the incoming word using the config sampled in the strobe cycle
    logic [3:0] n_bits;
    logic [3:0] stop_idx;
    logic [3:0] stop2_idx;
    rx_entry_t  dec_entry;

    always_comb begin
        n_bits    = 4'd5 + {2'b00, data_size_i};
        stop_idx  = n_bits + {3'b000, parity_en_i};
        stop2_idx = stop_idx + 4'd1;
        dec_entry = '0;
        for (int i = 0; i < 8; i++) begin
            dec_entry.data[i] = (4'(i) < n_bits) ? frame_i[i] : 1'b0;
        end
        dec_entry.parity_err = parity_en_i &
                               (frame_i[n_bits] != (^dec_entry.data ^ parity_odd_i));
        dec_entry.frame_err  = ~frame_i[stop_idx] | (stop_bits_i & ~frame_i[stop2_idx]);
    end

    // Decode stage register
    logic      dec_valid_q;
    rx_entry_t dec_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dec_valid_q <= 1'b0;
            dec_q       <= '0;
        end else begin
            dec_valid_q <= frame_valid_i;
            if (frame_valid_i) begin
                dec_q <= dec_entry;
            end
        end
    end

    // FIFO state
    rx_entry_t        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             overrun_q;
    rx_entry_t        head_q;
    logic             valid_q;

    rx_entry_t        mem_n [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_n;
    logic [PTR_W-1:0] rd_ptr_n;
    logic [CNT_W-1:0] cnt_n;
    logic             overrun_n;
    rx_entry_t        head_n;
    logic             full;
    logic             pop;
    logic             push_ok;

    // Next FIFO state; head outputs are precomputed so they come straight from flops
    always_comb begin
        mem_n     = mem_q;
        wr_ptr_n  = wr_ptr_q;
        rd_ptr_n  = rd_ptr_q;
        cnt_n     = cnt_q;
        overrun_n = overrun_q & ~overrun_clr_i;

        full    = (cnt_q == CNT_W'(FIFO_DEPTH));
        pop     = valid_q & rx_ready_i;
        // A same-cycle pop frees the slot, so a push on a full FIFO still lands
        push_ok = dec_valid_q & (~full | pop);

        if (dec_valid_q & full & ~pop) begin
            overrun_n = 1'b1;
        end
        if (push_ok) begin
            mem_n[wr_ptr_q] = dec_q;
            wr_ptr_n        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_n = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok & ~pop) begin
            cnt_n = cnt_q + CNT_W'(1);
        end else if (pop & ~push_ok) begin
            cnt_n = cnt_q - CNT_W'(1);
        end

        head_n = (cnt_n != '0) ? mem_n[rd_ptr_n] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            head_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            mem_q     <= mem_n;
            wr_ptr_q  <= wr_ptr_n;
            rd_ptr_q  <= rd_ptr_n;
            cnt_q     <= cnt_n;
            overrun_q <= overrun_n;
            head_q    <= head_n;
            valid_q   <= (cnt_n != '0);
        end
    end

    assign rx_data_o       = head_q.data;
    assign rx_parity_err_o = head_q.parity_err;
    assign rx_frame_err_o  = head_q.frame_err;
    assign rx_valid_o      = valid_q;
    assign fifo_count_o    = cnt_q;
    assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_rx_controller.sv
// Directed bench for rx_controller: frame formats, parity/stop errors,
// overrun, full FIFO with simultaneous push/pop, and mid-operation reset.
module tb_rx_controller;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [10:0] frame_i;
    logic        frame_valid_i;
    logic [1:0]  data_size_i;
    logic        parity_en_i;
    logic        parity_odd_i;
    logic        stop_bits_i;
    logic        rx_ready_i;
    logic        overrun_clr_i;
    logic [7:0]  rx_data_o;
    logic        rx_parity_err_o;
    logic        rx_frame_err_o;
    logic        rx_valid_o;
    logic [2:0]  fifo_count_o;
    logic        overrun_o;

    int vectors = 0;
    int miscompares = 0;

    rx_controller #(.FIFO_DEPTH(4)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .frame_i         (frame_i),
        .frame_valid_i   (frame_valid_i),
        .data_size_i     (data_size_i),
        .parity_en_i     (parity_en_i),
        .parity_odd_i    (parity_odd_i),
        .stop_bits_i     (stop_bits_i),
        .rx_ready_i      (rx_ready_i),
        .overrun_clr_i   (overrun_clr_i),
        .rx_data_o       (rx_data_o),
        .rx_parity_err_o (rx_parity_err_o),
        .rx_frame_err_o  (rx_frame_err_o),
        .rx_valid_o      (rx_valid_o),
        .fifo_count_o    (fifo_count_o),
        .overrun_o       (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic valid, input logic [7:0] data,
                              input logic perr, input logic ferr);
        check({tag, "_valid"}, 16'(rx_valid_o), 16'(valid));
        check({tag, "_data"},  16'(rx_data_o), 16'(data));
        check({tag, "_perr"},  16'(rx_parity_err_o), 16'(perr));
        check({tag, "_ferr"},  16'(rx_frame_err_o), 16'(ferr));
    endtask

    task automatic cfg(input logic [1:0] sz, input logic pen, input logic podd, input logic stp);
        data_size_i  = sz;
        parity_en_i  = pen;
        parity_odd_i = podd;
        stop_bits_i  = stp;
    endtask

    // Strobe one frame; returns in the cycle after the strobe
    task automatic send(input logic [10:0] f);
        frame_i       = f;
        frame_valid_i = 1'b1;
        tick();
        frame_valid_i = 1'b0;
    endtask

    task automatic pop_one();
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
    endtask

    initial begin
        rst_i         = 1'b1;
        frame_i       = '0;
        frame_valid_i = 1'b0;
        rx_ready_i    = 1'b0;
        overrun_clr_i = 1'b0;
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_i = 1'b0;

        // Reset state
        check_head("rst", 1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_count", 16'(fifo_count_o), 16'd0);
        check("rst_ovr", 16'(overrun_o), 16'd0);

        // 8N1 with two-cycle latency
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        send(11'h7A5);
        check("8n1_lat", 16'(rx_valid_o), 16'd0);
        tick();
        check_head("8n1", 1'b1, 8'hA5, 1'b0, 1'b0);
        check("8n1_count", 16'(fifo_count_o), 16'd1);
        pop_one();
        check_head("8n1_pop", 1'b0, 8'h00, 1'b0, 1'b0);

        // 7E1 parity error, then 7O1 clean
        cfg(2'b10, 1'b1, 1'b0, 1'b0);
        send(11'h7C1);
        tick();
        check_head("7e1", 1'b1, 8'h41, 1'b1, 1'b0);
        pop_one();
        cfg(2'b10, 1'b1, 1'b1, 1'b0);
        send(11'h7C1);
        tick();
        check_head("7o1", 1'b1, 8'h41, 1'b0, 1'b0);
        pop_one();

        // 8N2 second stop bit low, then 8N1 ignoring it
        cfg(2'b11, 1'b0, 1'b0, 1'b1);
        send(11'h5A5);
        tick();
        check_head("8n2", 1'b1, 8'hA5, 1'b0, 1'b1);
        pop_one();
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        send(11'h5A5);
        tick();
        check_head("8n1b", 1'b1, 8'hA5, 1'b0, 1'b0);
        pop_one();

        // 5N1 truncation: bits above data width cleared, stop at bit 5
        cfg(2'b00, 1'b0, 1'b0, 1'b0);
        send(11'h03F);
        tick();
        check_head("5n1", 1'b1, 8'h1F, 1'b0, 1'b0);
        pop_one();

        // Overrun: five back-to-back frames into a depth-4 FIFO
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            frame_i       = 11'h700 | 11'(i);
            frame_valid_i = 1'b1;
            tick();
        end
        frame_valid_i = 1'b0;
        check("ovr_pre", 16'(overrun_o), 16'd0);
        tick();
        check("ovr_set", 16'(overrun_o), 16'd1);
        check("ovr_count", 16'(fifo_count_o), 16'd4);
        for (int i = 1; i <= 4; i++) begin
            check_head($sformatf("ovr_pop%0d", i), 1'b1, 8'(i), 1'b0, 1'b0);
            pop_one();
        end
        check("ovr_empty", 16'(rx_valid_o), 16'd0);
        check("ovr_sticky", 16'(overrun_o), 16'd1);
        overrun_clr_i = 1'b1;
        tick();
        overrun_clr_i = 1'b0;
        check("ovr_clr", 16'(overrun_o), 16'd0);

        // Full FIFO with simultaneous pop and push of 0x99
        for (int i = 1; i <= 4; i++) begin
            send(11'h710 | 11'(i));
        end
        tick();
        check("full_count", 16'(fifo_count_o), 16'd4);
        send(11'h799);
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        check("pp_count", 16'(fifo_count_o), 16'd4);
        check("pp_ovr", 16'(overrun_o), 16'd0);
        for (int i = 2; i <= 4; i++) begin
            check($sformatf("pp_pop%0d", i), 16'(rx_data_o), 16'(8'h10 + 8'(i)));
            pop_one();
        end
        check_head("pp_last", 1'b1, 8'h99, 1'b0, 1'b0);
        pop_one();
        check("pp_empty", 16'(fifo_count_o), 16'd0);

        // Reset with three entries queued and a frame in the decode stage
        for (int i = 1; i <= 3; i++) begin
            send(11'h720 | 11'(i));
        end
        send(11'h7EE);
        check("pre_rst_count", 16'(fifo_count_o), 16'd3);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rr_count", 16'(fifo_count_o), 16'd0);
        check_head("rr", 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        check("rr_late_count", 16'(fifo_count_o), 16'd0);
        check("rr_late_valid", 16'(rx_valid_o), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
